// File: rtl/holosynth_audio_pkg.sv
// Shared definitions for the host audio register bus: address map, control
// and status bit positions, and the playback state encoding.
package holosynth_audio_pkg;

  localparam logic [2:0] ADDR_L    = 3'd0;
  localparam logic [2:0] ADDR_R    = 3'd1;
  localparam logic [2:0] ADDR_CTRL = 3'd2;
  localparam logic [2:0] ADDR_WM   = 3'd3;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int ST_UNDERRUN  = 16;
  localparam int ST_OVERRUN   = 17;
  localparam int ST_ENABLE    = 18;
  localparam int ST_LOW_WATER = 19;
  localparam int ST_STATE_LSB = 20;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_PLAY  = 2'd2
  } play_state_e;

endpackage

// File: rtl/stereo_fifo.sv
// Dual-pointer FIFO of stereo pairs. Pointers carry a wrap bit; the popped
// pair is registered and doubles as the consumer-facing output register.
module stereo_fifo #(
  parameter int FIFO_WIDTH = 6,
  parameter int DATA_W     = 48
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  logic                clr_data,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata,
  output logic                full,
  output logic                empty,
  output logic [FIFO_WIDTH:0] fill
);

  localparam int DEPTH = 1 << FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] PTR_ONE = 1;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [FIFO_WIDTH:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  assign fill  = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[FIFO_WIDTH] != rptr_q[FIFO_WIDTH]) &&
                 (wptr_q[FIFO_WIDTH-1:0] == rptr_q[FIFO_WIDTH-1:0]);
  assign rdata = rdata_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    rdata_d = rdata_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop)  rptr_d = rptr_q + PTR_ONE;
    end
    // Zeroing the output takes priority over presenting a popped pair.
    if (clr_data)           rdata_d = '0;
    else if (pop && !flush) rdata_d = mem[rptr_q[FIFO_WIDTH-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr_q[FIFO_WIDTH-1:0]] <= wdata;
  end

endmodule

// File: rtl/host_audio_sink.sv
// Host-written stereo playback path: register decode, FIFO, playback FSM
// and sticky xrun flags feeding the I2S transmitter / mixer.
module host_audio_sink
  import holosynth_audio_pkg::*;
#(
  parameter int FIFO_WIDTH    = 6,
  parameter int AUD_BIT_DEPTH = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2:0]               address,
  input  logic                     write,
  input  logic                     read,
  input  logic [31:0]              datain,
  output logic [31:0]              dataout,
  input  logic                     sample_tick,
  output logic [AUD_BIT_DEPTH-1:0] lsound_out,
  output logic [AUD_BIT_DEPTH-1:0] rsound_out,
  output logic                     sample_valid,
  output logic                     low_water
);

  localparam int W = AUD_BIT_DEPTH;
  localparam logic [FIFO_WIDTH:0] DEPTH_V = {1'b1, {FIFO_WIDTH{1'b0}}};

  play_state_e         state_q, state_d;
  logic [W-1:0]        l_hold_q, l_hold_d, wr_sample;
  logic                enable_q, enable_d;
  logic [FIFO_WIDTH:0] wm_q, wm_d;
  logic                underrun_q, underrun_d, overrun_q, overrun_d;
  logic                low_water_q, low_water_d, sample_valid_q, sample_valid_d;
  logic [31:0]         dataout_q, dataout_d, status;

  logic wr_l, wr_r, wr_ctrl, wr_wm, do_flush, do_clear;
  logic tick_play, pop_go, underrun_evt, push_go, overrun_evt, clr_data;

  logic                fifo_full, fifo_empty;
  logic [FIFO_WIDTH:0] fifo_fill;
  logic [2*W-1:0]      fifo_rdata;

  logic unused_datain;
  assign unused_datain = &{1'b0, datain};

  always_comb begin
    wr_sample = datain[31 -: W];
    wr_l      = write && (address == ADDR_L);
    wr_r      = write && (address == ADDR_R);
    wr_ctrl   = write && (address == ADDR_CTRL);
    wr_wm     = write && (address == ADDR_WM);
    do_flush  = wr_ctrl && datain[CTRL_FLUSH];
    do_clear  = wr_ctrl && datain[CTRL_CLEAR];

    tick_play    = sample_tick && enable_q && (state_q == S_PLAY);
    // Empty is judged before any same-cycle push; full after any same-cycle pop.
    pop_go       = tick_play && !fifo_empty && !do_flush;
    underrun_evt = tick_play && fifo_empty;
    push_go      = wr_r && !do_flush && (!fifo_full || pop_go);
    overrun_evt  = wr_r && !do_flush && fifo_full && !pop_go;
    clr_data     = !enable_q || (state_q == S_IDLE) || underrun_evt;
  end

  stereo_fifo #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .DATA_W     (2*W)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push_go),
    .pop      (pop_go),
    .flush    (do_flush),
    .clr_data (clr_data),
    .wdata    ({l_hold_q, wr_sample}),
    .rdata    (fifo_rdata),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .fill     (fifo_fill)
  );

  always_comb begin
    state_d = state_q;
    if (!enable_q) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  state_d = S_PRIME;
        S_PRIME: if (fifo_fill >= wm_q) state_d = S_PLAY;
        S_PLAY:  if (underrun_evt) state_d = S_PRIME;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    l_hold_d       = wr_l ? wr_sample : l_hold_q;
    enable_d       = wr_ctrl ? datain[CTRL_ENABLE] : enable_q;
    wm_d           = wr_wm ? datain[FIFO_WIDTH:0] : wm_q;
    underrun_d     = (underrun_q && !do_clear) || underrun_evt;
    overrun_d      = (overrun_q && !do_clear) || overrun_evt;
    low_water_d    = enable_q && (fifo_fill < wm_q);
    sample_valid_d = pop_go;

    status                         = '0;
    status[FIFO_WIDTH:0]           = fifo_fill;
    status[ST_UNDERRUN]            = underrun_q;
    status[ST_OVERRUN]             = overrun_q;
    status[ST_ENABLE]              = enable_q;
    status[ST_LOW_WATER]           = low_water_q;
    status[ST_STATE_LSB +: 2]      = state_q;

    dataout_d = dataout_q;
    if (read) begin
      unique case (address)
        ADDR_L:    dataout_d = status;
        ADDR_R:    dataout_d = 32'(DEPTH_V - fifo_fill);
        ADDR_CTRL: dataout_d = {31'd0, enable_q};
        ADDR_WM:   dataout_d = 32'(wm_q);
        default:   dataout_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      l_hold_q       <= '0;
      enable_q       <= 1'b0;
      wm_q           <= '0;
      underrun_q     <= 1'b0;
      overrun_q      <= 1'b0;
      low_water_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      dataout_q      <= '0;
    end else begin
      state_q        <= state_d;
      l_hold_q       <= l_hold_d;
      enable_q       <= enable_d;
      wm_q           <= wm_d;
      underrun_q     <= underrun_d;
      overrun_q      <= overrun_d;
      low_water_q    <= low_water_d;
      sample_valid_q <= sample_valid_d;
      dataout_q      <= dataout_d;
    end
  end

  assign dataout      = dataout_q;
  assign lsound_out   = fifo_rdata[2*W-1:W];
  assign rsound_out   = fifo_rdata[W-1:0];
  assign sample_valid = sample_valid_q;
  assign low_water    = low_water_q;

endmodule

// File: tb/tb_host_audio_sink.sv
// Directed bench for host_audio_sink: priming, playback order, xruns,
// simultaneous push/pop, flush, pointer wrap streaming and async reset.
module tb_host_audio_sink;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] datain = '0;
  logic [31:0] dataout;
  logic        sample_tick = 1'b0;
  logic [23:0] lsound_out, rsound_out;
  logic        sample_valid, low_water;

  int errors = 0;
  int checks = 0;

  host_audio_sink #(.FIFO_WIDTH(6), .AUD_BIT_DEPTH(24)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .write        (write),
    .read         (read),
    .datain       (datain),
    .dataout      (dataout),
    .sample_tick  (sample_tick),
    .lsound_out   (lsound_out),
    .rsound_out   (rsound_out),
    .sample_valid (sample_valid),
    .low_water    (low_water)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; datain = d; write = 1'b1;
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic host_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; read = 1'b1;
    @(posedge clk);
    #1 read = 1'b0;
    d = dataout;
  endtask

  task automatic push_pair(input logic [23:0] l, input logic [23:0] r);
    host_write(3'd0, {l, 8'h00});
    host_write(3'd1, {r, 8'h00});
  endtask

  task automatic do_tick;
    @(negedge clk);
    sample_tick = 1'b1;
    @(posedge clk);
    #1 sample_tick = 1'b0;
  endtask

  // Right-sample write and a tick land on the same edge.
  task automatic push_r_with_tick(input logic [23:0] r);
    @(negedge clk);
    address = 3'd1; datain = {r, 8'h00}; write = 1'b1; sample_tick = 1'b1;
    @(posedge clk);
    #1 write = 1'b0; sample_tick = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    int          fill_m;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {dataout, lsound_out, rsound_out, sample_valid, low_water}, '0);
    reset_n = 1'b1;
    host_read(3'd0, rd);
    check("reset_status", rd, 32'h0);

    // Prime with wm=4, then play four pairs in order.
    host_write(3'd3, 32'd4);
    host_write(3'd2, 32'd1);
    for (int i = 0; i < 4; i++) push_pair(24'h100000 + 24'(i), 24'h200000 + 24'(i));
    @(negedge clk);
    check("low_water_lag_hi", low_water, 1'b1);
    @(negedge clk);
    check("low_water_lag_lo", low_water, 1'b0);
    host_read(3'd0, rd);
    check("status_primed_play", rd, 32'h0024_0004);
    for (int i = 0; i < 4; i++) begin
      do_tick();
      check("play_pair", {sample_valid, lsound_out, rsound_out},
            {1'b1, 24'h100000 + 24'(i), 24'h200000 + 24'(i)});
    end
    @(posedge clk); #1;
    check("valid_one_cycle", sample_valid, 1'b0);
    host_read(3'd0, rd);
    check("status_drained", rd, 32'h002C_0000);

    // Underrun on an empty PLAY tick.
    do_tick();
    check("underrun_outputs", {sample_valid, lsound_out, rsound_out}, '0);
    host_read(3'd0, rd);
    check("status_underrun", rd, 32'h001D_0000);

    // Overrun: 64 pairs fill the FIFO, the 65th is dropped.
    host_write(3'd2, 32'd3);
    for (int i = 0; i < 64; i++) push_pair(24'h300000 + 24'(i), 24'h400000 + 24'(i));
    push_pair(24'h3FFFFF, 24'h4FFFFF);
    host_read(3'd0, rd);
    check("status_overrun", rd, 32'h0026_0040);
    host_read(3'd1, rd);
    check("free_full", rd, 32'd0);
    host_write(3'd2, 32'd3);
    host_read(3'd0, rd);
    check("status_ovr_cleared", rd, 32'h0024_0040);

    // Full FIFO: push and pop on the same edge both happen.
    host_write(3'd0, {24'h500000, 8'h00});
    push_r_with_tick(24'h600000);
    check("full_push_pop_out", {sample_valid, lsound_out, rsound_out}, {1'b1, 24'h300000, 24'h400000});
    host_read(3'd0, rd);
    check("status_full_push_pop", rd, 32'h0024_0040);
    for (int i = 1; i < 64; i++) begin
      do_tick();
      check("drain_pair", {lsound_out, rsound_out}, {24'h300000 + 24'(i), 24'h400000 + 24'(i)});
    end
    do_tick();
    check("drain_last_not_65th", {sample_valid, lsound_out, rsound_out}, {1'b1, 24'h500000, 24'h600000});

    // Empty FIFO: push and tick together underrun, and the pair is kept.
    host_write(3'd0, {24'h700000, 8'h00});
    push_r_with_tick(24'h710000);
    check("empty_push_pop_out", {sample_valid, lsound_out, rsound_out}, '0);
    host_read(3'd0, rd);
    check("status_empty_push_pop", rd, 32'h001D_0001);

    // Flush plus clear keeps enable, empties the FIFO.
    host_write(3'd2, 32'd7);
    host_read(3'd0, rd);
    check("status_flush", rd, 32'h001C_0000);

    // Stream 200 pairs through the pointer wrap with wm=2.
    host_write(3'd3, 32'd2);
    push_pair(24'hA00000, 24'hC00000);
    push_pair(24'hA00001, 24'hBFFFFF);
    fill_m = 2;
    for (int i = 0; i < 200; i++) begin
      if (i + 2 < 200) begin
        push_pair(24'hA00000 + 24'(i + 2), 24'hC00000 - 24'(i + 2));
        fill_m++;
      end
      do_tick();
      check("stream_pair", {sample_valid, lsound_out, rsound_out},
            {1'b1, 24'hA00000 + 24'(i), 24'hC00000 - 24'(i)});
      check("stream_low_water", low_water, (fill_m < 2));
      fill_m--;
    end
    host_read(3'd0, rd);
    check("status_stream_end", rd, 32'h002C_0000);
    host_read(3'd2, rd);
    check("ctrl_readback", rd, 32'd1);
    host_read(3'd3, rd);
    check("wm_readback", rd, 32'd2);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {dataout, lsound_out, rsound_out, sample_valid, low_water}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    host_read(3'd0, rd);
    check("status_after_reset", rd, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
